codec_i2c_responder: RTL and testbench

I2C target (responder) that accepts the 3-byte codec register-write transaction: device address, then {7-bit register address, data bit 8}, then data bits 7:0. It decodes writes addressed to the codec's device address and ACKs each byte on SDA. Accepted words go into an internal 9-bit register file, with a one-cycle write strobe for each. It is the receiving end of the codec configuration link: it is used as the on-chip codec model in simulation and as an emulated codec target on the board.

---
 rtl/codec_i2c_responder_if.sv | 10 +
 rtl/codec_i2c_responder.sv | 145 ++++++++++++++
 tb/tb_codec_i2c_responder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/codec_i2c_responder_if.sv
// codec_i2c_responder_if: open-drain I2C bus; sda is the wired-AND of initiator and responder drives.
interface codec_i2c_responder_if;
    logic scl;
    logic sda_m;
    logic sda_oe;
    logic sda;
    assign sda = sda_m & ~sda_oe;
    modport master (output scl, output sda_m, input sda);
    modport slave  (input scl, input sda, output sda_oe);
endinterface

// File: rtl/codec_i2c_responder.sv
// codec_i2c_responder: write-only I2C codec target storing 3-byte register writes in a 9-bit register file.
module codec_i2c_responder #(
    parameter logic [7:0] DEVICE_ADDR = 8'h34,
    parameter int         NUM_REGS    = 16
) (
    input  logic                        inClock,
    input  logic                        reset,
    codec_i2c_responder_if.slave        bus,
    output logic [6:0]                  regAddr,
    output logic [8:0]                  regData,
    output logic                        regWrite,
    output logic                        busy,
    output logic [3:0]                  writeCount,
    input  logic [3:0]                  rdAddr,
    output logic [8:0]                  rdData
);
    localparam int         AW    = $clog2(NUM_REGS);
    localparam logic [7:0] NREGS = 8'(NUM_REGS);

    typedef enum logic [2:0] {
        S_IDLE, S_DEV, S_ACKD, S_B1, S_ACK1, S_B2, S_ACK2, S_IGN
    } state_t;

    logic [1:0] r_scl_s, r_sda_s;
    logic       r_scl_h, r_sda_h;
    logic       r_rise, r_fall, r_start, r_stop, r_bit;
    state_t     r_state, w_state;
    logic [3:0] r_cnt, w_cnt;
    logic [7:0] r_sh, w_sh;
    logic [6:0] r_addr, w_addr;
    logic       r_d8, w_d8;
    logic       w_commit, w_full, w_dev_ok;
    logic [8:0] r_file [NUM_REGS];
    logic [6:0] r_reg_addr;
    logic [8:0] r_reg_data, r_rd;
    logic       r_write, r_busy;
    logic [3:0] r_wcnt;

    assign w_full   = r_cnt == 4'd8;
    assign w_dev_ok = r_sh[7:1] == DEVICE_ADDR[7:1] && !r_sh[0];

    // ACK pull-down is gated by reset so it releases without waiting for a clock
    assign bus.sda_oe = reset && r_state inside {S_ACKD, S_ACK1, S_ACK2};

    assign regAddr    = r_reg_addr;
    assign regData    = r_reg_data;
    assign regWrite   = r_write;
    assign busy       = r_busy;
    assign writeCount = r_wcnt;
    assign rdData     = r_rd;

    // synchronizers idle high so reset release on a quiet bus sees no edge
    always_ff @(posedge inClock or negedge reset) begin
        if (!reset) begin
            r_scl_s <= 2'b11;
            r_sda_s <= 2'b11;
            r_scl_h <= 1'b1;
            r_sda_h <= 1'b1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_start <= 1'b0;
            r_stop  <= 1'b0;
            r_bit   <= 1'b1;
        end else begin
            r_scl_s <= {r_scl_s[0], bus.scl};
            r_sda_s <= {r_sda_s[0], bus.sda};
            r_scl_h <= r_scl_s[1];
            r_sda_h <= r_sda_s[1];
            r_rise  <= r_scl_s[1] & ~r_scl_h;
            r_fall  <= ~r_scl_s[1] & r_scl_h;
            r_start <= r_scl_s[1] & r_scl_h & r_sda_h & ~r_sda_s[1];
            r_stop  <= r_scl_s[1] & r_scl_h & ~r_sda_h & r_sda_s[1];
            r_bit   <= r_sda_s[1];
        end
    end

    always_ff @(posedge inClock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sh    <= '0;
            r_addr  <= '0;
            r_d8    <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_sh    <= w_sh;
            r_addr  <= w_addr;
            r_d8    <= w_d8;
        end
    end

    // STOP outranks START, which outranks any bit or ACK activity
    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_sh     = r_sh;
        w_addr   = r_addr;
        w_d8     = r_d8;
        w_commit = 1'b0;
        if (r_stop) begin
            w_state = S_IDLE;
        end else if (r_start) begin
            w_state = S_DEV;
            w_cnt   = '0;
        end else if (r_state inside {S_DEV, S_B1, S_B2}) begin
            if (r_rise && !w_full) begin
                w_sh  = {r_sh[6:0], r_bit};
                w_cnt = r_cnt + 4'd1;
            end else if (r_fall && w_full) begin
                w_state = r_state == S_B2 ? S_ACK2 :
                          r_state == S_B1 ? S_ACK1 :
                          w_dev_ok        ? S_ACKD : S_IGN;
                w_addr  = r_state == S_B1 ? r_sh[7:1] : r_addr;
                w_d8    = r_state == S_B1 ? r_sh[0]   : r_d8;
            end
        end else if (r_fall && r_state inside {S_ACKD, S_ACK1, S_ACK2}) begin
            w_state  = r_state == S_ACKD ? S_B1 : r_state == S_ACK1 ? S_B2 : S_IGN;
            w_cnt    = '0;
            w_commit = r_state == S_ACK2 && {1'b0, r_addr} < NREGS;
        end
    end

    always_ff @(posedge inClock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) r_file[i] <= '0;
            r_reg_addr <= '0;
            r_reg_data <= '0;
            r_write    <= 1'b0;
            r_busy     <= 1'b0;
            r_wcnt     <= '0;
            r_rd       <= '0;
        end else begin
            if (w_commit) begin
                r_file[r_addr[AW-1:0]] <= {r_d8, r_sh};
                r_reg_addr             <= r_addr;
                r_reg_data             <= {r_d8, r_sh};
                r_wcnt                 <= r_wcnt + 4'd1;
            end
            r_write <= w_commit;
            r_busy  <= r_stop ? 1'b0 : r_start ? 1'b1 : r_busy;
            r_rd    <= r_file[rdAddr];
        end
    end
endmodule

// File: tb/tb_codec_i2c_responder.sv
// tb_codec_i2c_responder: bit-banged I2C initiator with a transaction-level codec model.
module tb_codec_i2c_responder;
    localparam int Q = 8;

    logic       inClock = 1'b0;
    logic       reset   = 1'b0;
    logic [3:0] rdAddr  = '0;
    logic [6:0] regAddr;
    logic [8:0] regData;
    logic       regWrite;
    logic       busy;
    logic [3:0] writeCount;
    logic [8:0] rdData;

    codec_i2c_responder_if bus();

    codec_i2c_responder dut (
        .inClock    (inClock),
        .reset      (reset),
        .bus        (bus),
        .regAddr    (regAddr),
        .regData    (regData),
        .regWrite   (regWrite),
        .busy       (busy),
        .writeCount (writeCount),
        .rdAddr     (rdAddr),
        .rdData     (rdData)
    );

    always #5 inClock = ~inClock;

    int n_chk = 0;
    int n_fail = 0;
    int pulses = 0;
    int dbl = 0;
    logic prev_w = 1'b0;

    logic [8:0] m_reg [16];
    logic [6:0] m_addr;
    logic [8:0] m_data;
    int         m_cnt;
    int         m_pulses;

    always @(negedge inClock) begin
        if (regWrite) pulses++;
        if (regWrite && prev_w) dbl++;
        prev_w = regWrite;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic wq(input int n);
        repeat (n) @(negedge inClock);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = '0;
        m_addr = '0;
        m_data = '0;
        m_cnt  = 0;
    endtask

    task automatic i2c_start();
        bus.sda_m = 1'b0; wq(Q);
        bus.scl   = 1'b0; wq(Q);
    endtask

    task automatic i2c_rstart();
        bus.sda_m = 1'b1; wq(Q);
        bus.scl   = 1'b1; wq(Q);
        bus.sda_m = 1'b0; wq(Q);
        bus.scl   = 1'b0; wq(Q);
    endtask

    task automatic i2c_stop();
        bus.sda_m = 1'b0; wq(Q);
        bus.scl   = 1'b1; wq(Q);
        bus.sda_m = 1'b1; wq(Q);
    endtask

    task automatic wbits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            bus.sda_m = b[i]; wq(Q);
            bus.scl   = 1'b1; wq(2 * Q);
            bus.scl   = 1'b0; wq(Q);
        end
    endtask

    task automatic wbyte(input logic [7:0] b, output logic ack);
        wbits(b);
        bus.sda_m = 1'b1; wq(Q);
        bus.scl   = 1'b1; wq(Q);
        ack = ~bus.sda;   wq(Q);
        bus.scl   = 1'b0; wq(Q);
    endtask

    // codec rules: only write-form 0x34/0x35-family addresses with R/W=0 are acked, three bytes max
    task automatic txn(input logic [31:0] bv, input int n, input bit rep);
        logic [7:0] b [4];
        logic       ack;
        bit         ok;
        int         a;
        for (int i = 0; i < 4; i++) b[i] = bv[31 - 8 * i -: 8];
        if (rep) i2c_rstart(); else i2c_start();
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        ok = (b[0] >> 1) == 8'h1A && b[0][0] == 1'b0;
        for (int i = 0; i < n; i++) begin
            wbyte(b[i], ack);
            chk($sformatf("ack_byte%0d_%02h", i, b[i]), {31'd0, ack}, {31'd0, ok && i < 3});
        end
        a = int'(b[1]) / 2;
        if (ok && n >= 3 && a < 16) begin
            m_reg[a] = {b[1][0], b[2]};
            m_addr   = 7'(a);
            m_data   = {b[1][0], b[2]};
            m_cnt++;
            m_pulses++;
        end
    endtask

    task automatic stop_chk();
        i2c_stop();
        wq(8);
        chk("busy_after_stop", {31'd0, busy}, 32'd0);
        chk("writeCount", {28'd0, writeCount}, 32'(m_cnt % 16));
        chk("regAddr", {25'd0, regAddr}, {25'd0, m_addr});
        chk("regData", {23'd0, regData}, {23'd0, m_data});
        chk("regWrite_pulses", 32'(pulses), 32'(m_pulses));
        chk("regWrite_width", 32'(dbl), 32'd0);
    endtask

    task automatic rd(input int a);
        rdAddr = 4'(a);
        wq(2);
        chk($sformatf("rdData_%0d", a), {23'd0, rdData}, {23'd0, m_reg[a]});
    endtask

    initial begin
        logic [31:0] bv;
        logic [7:0]  dv;
        logic        ack;
        int          n;
        bit          rep;
        bus.scl   = 1'b1;
        bus.sda_m = 1'b1;
        model_reset();
        m_pulses = 0;
        wq(3);
        chk("rst_sda", {31'd0, bus.sda}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_regWrite", {31'd0, regWrite}, 32'd0);
        chk("rst_writeCount", {28'd0, writeCount}, 32'd0);
        chk("rst_regAddr", {25'd0, regAddr}, 32'd0);
        chk("rst_regData", {23'd0, regData}, 32'd0);
        chk("rst_rdData", {23'd0, rdData}, 32'd0);
        reset = 1'b1;
        wq(4);

        txn(32'h34080400, 3, 1'b0); stop_chk(); rd(4);
        txn(32'h340D3900, 3, 1'b0); stop_chk(); rd(6);
        txn(32'h340E4200, 3, 1'b0); stop_chk(); rd(7);
        txn(32'h36000000, 1, 1'b0); stop_chk();
        txn(32'h35000000, 1, 1'b0); stop_chk();
        txn(32'h34080000, 2, 1'b0); stop_chk(); rd(4);
        txn(32'h340E0000, 2, 1'b0);
        txn(32'h34021700, 3, 1'b1); stop_chk(); rd(1); rd(7);
        txn(32'h34205566, 4, 1'b0); stop_chk(); rd(0);

        rep = 1'b0;
        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 3))
                0, 1:    dv = 8'h34;
                2:       dv = $urandom_range(0, 1) ? 8'h35 : 8'h36;
                default: dv = 8'($urandom);
            endcase
            bv = {dv, 7'($urandom_range(0, 21)), 1'($urandom), 8'($urandom), 8'($urandom)};
            n  = $urandom_range(1, 4);
            txn(bv, n, rep);
            if (k < 23 && $urandom_range(0, 3) == 0) rep = 1'b1;
            else begin
                stop_chk();
                rep = 1'b0;
            end
        end
        for (int i = 0; i < 16; i++) rd(i);

        i2c_start();
        wbits(8'h34);
        bus.sda_m = 1'b1; wq(Q);
        bus.scl   = 1'b1; wq(Q);
        chk("ack_before_reset", {31'd0, bus.sda}, 32'd0);
        reset = 1'b0;
        #1;
        chk("sda_released_in_reset", {31'd0, bus.sda}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_writeCount", {28'd0, writeCount}, 32'd0);
        chk("reset_regAddr", {25'd0, regAddr}, 32'd0);
        chk("reset_regData", {23'd0, regData}, 32'd0);
        chk("reset_rdData", {23'd0, rdData}, 32'd0);
        model_reset();
        wq(4);
        reset = 1'b1;
        wq(Q);
        bus.scl = 1'b0; wq(Q);
        wbyte(8'h34, ack);
        chk("no_start_nack", {31'd0, ack}, 32'd0);
        stop_chk();
        rd(4); rd(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
